inst_fetch_unit: RTL and testbench

//   Fetch stage of the npc core; sits directly upstream of the instruction decoder / ControlUnit.

---
 rtl/inst_fetch_unit.sv | 122 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - npc fetch stage: PC, imem handshake, next-PC on commit, sticky faults
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        commit_valid,
  input  logic        pc_asrc,
  input  logic        pc_bsrc,
  input  logic [31:0] imm,
  input  logic [31:0] src1,
  input  logic        halt_req,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_cause;
  logic [31:0]   r_fault_pc;

  logic [31:0] w_base;
  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic [31:0] w_next;
  logic        w_misaligned;
  logic        w_expire;

  assign w_base   = pc_bsrc ? src1 : r_pc;
  assign w_addend = pc_asrc ? imm : 32'd4;
  assign w_sum    = w_base + w_addend;
  // JALR targets drop bit 0 before the alignment check.
  assign w_next       = {w_sum[31:1], w_sum[0] & ~pc_bsrc};
  assign w_misaligned = (w_next[1:0] != 2'b00);
  assign w_expire     = (TIMEOUT != 0) && (r_timer == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst     <= 32'd0;
      r_timer    <= '0;
      r_cause    <= 2'b00;
      r_fault_pc <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!halt_req) r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_state <= S_WAIT;
            r_timer <= '0;
          end
        end
        S_WAIT: begin
          if (r_timer != '1) r_timer <= r_timer + TW'(1);
          // A response arriving in the expiry cycle takes priority over the timeout.
          if (imem_rsp_valid && !imem_rsp_err) begin
            r_inst  <= imem_rsp_data;
            r_state <= S_HOLD;
          end else if (imem_rsp_valid) begin
            r_cause    <= 2'b01;
            r_fault_pc <= r_pc;
            r_state    <= S_FAULT;
          end else if (w_expire) begin
            r_cause    <= 2'b10;
            r_fault_pc <= r_pc;
            r_state    <= S_FAULT;
          end
        end
        S_HOLD: begin
          if (commit_valid) begin
            if (w_misaligned) begin
              r_cause    <= 2'b11;
              r_fault_pc <= w_next;
              r_state    <= S_FAULT;
            end else begin
              r_pc    <= w_next;
              r_state <= halt_req ? S_IDLE : S_REQ;
            end
          end
        end
        default: r_state <= S_FAULT;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_pc;
  assign fault          = (r_state == S_FAULT);
  assign fault_cause    = r_cause;
  assign fault_pc       = r_fault_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid = 1'b0;
  logic        pc_asrc = 1'b0;
  logic        pc_bsrc = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] src1 = 32'd0;
  logic        halt_req = 1'b0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  inst_fetch_unit #(.RESET_PC(32'h8000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .commit_valid(commit_valid), .pc_asrc(pc_asrc), .pc_bsrc(pc_bsrc), .imm(imm), .src1(src1),
    .halt_req(halt_req), .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, check its address, then handshake into WAIT.
  task automatic issue(input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] exp_pc);
    logic [63:0] e;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    sb.push_back({data, exp_pc});
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    if (inst_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", inst, e[63:32]);
      chk("inst_pc", inst_pc, e[31:0]);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    issue(addr);
    respond(data, addr);
  endtask

  task automatic commit(input logic a, input logic b, input logic [31:0] im, input logic [31:0] s1, input logic h);
    pc_asrc = a; pc_bsrc = b; imm = im; src1 = s1; halt_req = h;
    commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cause", {30'd0, fault_cause}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    rst = 1'b0;

    fetch(32'h8000_0000, 32'h0000_0013);
    commit(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("no_bubble", {31'd0, imem_req_valid}, 32'd1);
    fetch(32'h8000_0004, 32'h0010_0093);
    commit(1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0);
    fetch(32'h7FFF_FFFC, 32'h0020_0113);
    commit(1'b1, 1'b1, 32'd0, 32'h8000_1001, 1'b0);
    chk("jalr_no_fault", {31'd0, fault}, 32'd0);
    fetch(32'h8000_1000, 32'h0030_0193);

    commit(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_req_addr, 32'h8000_1004);
      @(negedge clk);
    end
    fetch(32'h8000_1004, 32'h0040_0213);

    commit(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("halt_pc", imem_req_addr, 32'h8000_1008);
      @(negedge clk);
    end
    halt_req = 1'b0;
    fetch(32'h8000_1008, 32'h0050_0293);

    commit(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    issue(32'h8000_100C);
    rst = 1'b1;
    halt_req = 1'b1;
    #1;
    chk("midrst_pc", imem_req_addr, 32'h8000_0000);
    chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("stray_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stray_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stray_inst", inst, 32'd0);
    halt_req = 1'b0;

    fetch(32'h8000_0000, 32'h0060_0313);
    commit(1'b1, 1'b0, 32'd6, 32'd0, 1'b0);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_cause", {30'd0, fault_cause}, 32'd3);
    chk("mis_fault_pc", fault_pc, 32'h8000_0006);
    chk("mis_pc_kept", imem_req_addr, 32'h8000_0000);
    imem_rsp_valid = 1'b1;
    commit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;
    commit_valid = 1'b0;
    chk("fault_sticky", {29'd0, fault, fault_cause}, 32'd7);

    do_reset();
    issue(32'h8000_0000);
    repeat (15) @(negedge clk);
    chk("expiry_no_fault", {31'd0, fault}, 32'd0);
    respond(32'h0070_0393, 32'h8000_0000);
    chk("expiry_rsp_wins", {31'd0, fault}, 32'd0);

    do_reset();
    issue(32'h8000_0000);
    for (int i = 1; i < 16; i++) begin
      chk("to_pending", {31'd0, fault}, 32'd0);
      @(negedge clk);
    end
    chk("to_pending_last", {31'd0, fault}, 32'd0);
    @(negedge clk);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_cause", {30'd0, fault_cause}, 32'd2);
    chk("to_fault_pc", fault_pc, 32'h8000_0000);

    do_reset();
    issue(32'h8000_0000);
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("err_fault", {31'd0, fault}, 32'd1);
    chk("err_cause", {30'd0, fault_cause}, 32'd1);
    chk("err_fault_pc", fault_pc, 32'h8000_0000);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
